phase_clock_divider: RTL
========================

Name: phase_clock_divider

Overview:
- Parametrised successor to the fixed divide-by-2 clock divider that feeds the processor and memory clock domains.
- Generates a divided clock and its complement, plus single-cycle rise/fall enables, all from one master clock.
- Divisor is runtime-programmable and glitch-free, applied only at period boundaries.
- Adds halt and single-step control, so the processor/regfile clocks can be frozen and advanced one period at a time for debug.

Parameters:
- CNT_WIDTH, 8, width of the divisor and of the internal phase counter.
- RESET_DIV, 2, active divide ratio after reset; must be >= 2.
- PCNT_WIDTH, 32, width of the divided-period counter.

Ports:
- clock  input  1  master clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- div_ratio  input  CNT_WIDTH  requested divide ratio N.
- div_load  input  1  one-cycle pulse; captures div_ratio into the pending register.
- halt  input  1  level; 1 = stop after the current period completes.
- step  input  1  one-cycle pulse; while halted, run exactly one period.
- div_clk  output  1  divided clock, registered.
- div_clk_n  output  1  registered complement of div_clk; 0 while halted.
- rise_en  output  1  high in the first cycle of each div_clk high phase.
- fall_en  output  1  high in the first cycle of each div_clk low phase.
- halted  output  1  high while the state machine is in HALTED.
- cur_div  output  CNT_WIDTH  currently active ratio.
- period_count  output  PCNT_WIDTH  number of periods started; wraps modulo 2^PCNT_WIDTH.

Behaviour:
- Reset (asynchronous, immediate, including mid-period):
  - All outputs 0; cur_div = RESET_DIV; pending load cleared.
  - Internal phase counter parked at boundary; state = IDLE.
- Phase counter cnt runs 0..N-1 while a period is active.
  - div_clk = 1 for cnt < ceil(N/2), else 0: N=2 gives 1H/1L, N=5 gives 3H/2L.
  - div_clk_n = ~div_clk while running.
- rise_en and fall_en are registered and coincident with the first cycle of their phase.
  - For N=2 both pulse on alternate cycles.
- period_count increments in the same cycle rise_en is asserted.
- Ratio clamp: div_ratio < 2 (0 or 1) is loaded as 2.
- Ratio update:
  - div_load writes the pending register; a second load before application overwrites it.
  - Pending value becomes cur_div at the next period start.
  - A load in the cycle cnt==N-1 applies to the period starting next cycle.
  - In HALTED, a load applies immediately (cur_div updates next cycle).
- States IDLE, RUN, HALTED, STEP:
  - IDLE (after reset only): next edge, halt=0 → RUN and period 0 begins (div_clk=1, rise_en=1, period_count=1); halt=1 → HALTED with no pulse.
  - RUN: at cnt==N-1, halt=1 → HALTED, with div_clk low and no rise_en next cycle; otherwise a new period starts. halt is never honoured mid-period, so no truncated pulses. step is ignored.
  - HALTED: cnt held at 0; div_clk=0, div_clk_n=0, enables 0, halted=1. halt=0 → RUN and a period starts next cycle. Otherwise step → STEP and a period starts next cycle.
  - STEP: completes one full period. At cnt==N-1, halt=1 → HALTED, else RUN. Further step pulses during STEP are ignored.
- Simultaneous events:
  - In HALTED, halt=0 together with step → RUN; step is absorbed.
  - div_load together with a period start → the new value applies at the following boundary.
- Latency: halt release to rise_en = 1 cycle; step pulse to rise_en = 1 cycle.

Test Plan:
- Reset release, halt=0, default N=2 → div_clk toggles every cycle; rise_en/fall_en alternate; period_count=4 after 8 cycles.
- div_ratio=5 load mid-period → current period finishes at old N. Then div_clk 3 high, 2 low repeating; cur_div=5 from the first rise_en after load.
- halt=1 asserted at cnt=1 with N=4 → period completes (cnt 2,3 low), then halted=1 and div_clk stays 0; rise_en absent for 10 cycles.
- In HALTED with N=3, step pulse → exactly one period (div_clk 1,1,0), period_count +1, halted=1 again. A second step during STEP is ignored.
- div_ratio=0 and =1 loaded → cur_div=2; reset asserted mid-period with N=6 → all outputs 0 immediately, cur_div=2.
- period_count preset near wrap (PCNT_WIDTH=4, 15 periods) → after 16th rise_en it reads 0.

Source files
------------

// File: rtl/phase_clock_divider.sv
// Phase clock divider: programmable divide-by-N clock with complement,
// rise/fall enables, period counter and halt/single-step debug control.
// Divisor changes take effect only at period boundaries so the divided
// clock never produces a truncated high or low phase.
module phase_clock_divider #(
    parameter int CNT_WIDTH  = 8,
    parameter int RESET_DIV  = 2,
    parameter int PCNT_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CNT_WIDTH-1:0]  div_ratio,
    input  logic                  div_load,
    input  logic                  halt,
    input  logic                  step,
    output logic                  div_clk,
    output logic                  div_clk_n,
    output logic                  rise_en,
    output logic                  fall_en,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  cur_div,
    output logic [PCNT_WIDTH-1:0] period_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  r_curDiv;
    logic [CNT_WIDTH-1:0]  r_pendDiv;
    logic                  r_pendValid;
    logic                  r_divClk;
    logic                  r_divClkN;
    logic                  r_riseEn;
    logic                  r_fallEn;
    logic [PCNT_WIDTH-1:0] r_periodCount;

    logic                  w_start;
    logic                  w_advance;
    logic                  w_atEnd;
    logic [CNT_WIDTH-1:0]  w_loadVal;
    logic [CNT_WIDTH-1:0]  w_startDiv;
    logic [CNT_WIDTH-1:0]  w_cntInc;
    logic [CNT_WIDTH:0]    w_halfDiv;
    logic                  w_incHigh;
    logic                  w_incFall;

    // Datapath helpers: clamped load value, the ratio a new period would
    // use, and the high/low decision for the next phase count. The high
    // length ceil(N/2) is computed one bit wider so N at full scale works.
    always_comb begin
        w_loadVal  = (div_ratio < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : div_ratio;
        w_startDiv = div_load ? w_loadVal : (r_pendValid ? r_pendDiv : r_curDiv);
        w_atEnd    = (r_cnt == (r_curDiv - CNT_WIDTH'(1)));
        w_cntInc   = r_cnt + CNT_WIDTH'(1);
        w_halfDiv  = ({1'b0, r_curDiv} + {{CNT_WIDTH{1'b0}}, 1'b1}) >> 1;
        w_incHigh  = ({1'b0, w_cntInc} < w_halfDiv);
        w_incFall  = ({1'b0, w_cntInc} == w_halfDiv);
    end

    // Next-state logic: decides whether the coming cycle starts a period,
    // continues the current one, or parks the divider in HALTED.
    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (halt) begin
                    w_stateNext = HALTED;
                end else begin
                    w_stateNext = RUN;
                    w_start     = 1'b1;
                end
            end
            RUN, STEP: begin
                if (w_atEnd) begin
                    if (halt) begin
                        w_stateNext = HALTED;
                    end else begin
                        w_stateNext = RUN;
                        w_start     = 1'b1;
                    end
                end else begin
                    w_advance = 1'b1;
                end
            end
            HALTED: begin
                if (!halt) begin
                    w_stateNext = RUN;
                    w_start     = 1'b1;
                end else if (step) begin
                    w_stateNext = STEP;
                    w_start     = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State, phase counter, ratio registers and registered outputs. Outputs
    // are computed from the upcoming phase so they line up with it exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_curDiv      <= CNT_WIDTH'(RESET_DIV);
            r_pendDiv     <= '0;
            r_pendValid   <= 1'b0;
            r_divClk      <= 1'b0;
            r_divClkN     <= 1'b0;
            r_riseEn      <= 1'b0;
            r_fallEn      <= 1'b0;
            r_periodCount <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_start) begin
                r_cnt         <= '0;
                r_curDiv      <= w_startDiv;
                r_pendValid   <= 1'b0;
                r_divClk      <= 1'b1;
                r_divClkN     <= 1'b0;
                r_riseEn      <= 1'b1;
                r_fallEn      <= 1'b0;
                r_periodCount <= r_periodCount + PCNT_WIDTH'(1);
            end else if (w_advance) begin
                r_cnt     <= w_cntInc;
                r_divClk  <= w_incHigh;
                r_divClkN <= !w_incHigh;
                r_riseEn  <= 1'b0;
                r_fallEn  <= w_incFall;
                if (div_load) begin
                    r_pendDiv   <= w_loadVal;
                    r_pendValid <= 1'b1;
                end
            end else begin
                r_cnt     <= '0;
                r_divClk  <= 1'b0;
                r_divClkN <= 1'b0;
                r_riseEn  <= 1'b0;
                r_fallEn  <= 1'b0;
                if (div_load) begin
                    r_curDiv    <= w_loadVal;
                    r_pendValid <= 1'b0;
                end
            end
        end
    end

    assign div_clk      = r_divClk;
    assign div_clk_n    = r_divClkN;
    assign rise_en      = r_riseEn;
    assign fall_en      = r_fallEn;
    assign halted       = (r_state == HALTED);
    assign cur_div      = r_curDiv;
    assign period_count = r_periodCount;

endmodule
